// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the time-multiplexed FIR MAC scheduler.
// WORD_LENGTH/TAPS/ACC_W are the engine's fixed dimensions (Q1.15, 32 taps).
package fir_sched_pkg;

    localparam int WORD_LENGTH = 16;
    localparam int TAPS        = 32;
    localparam int TAP_W       = 5;
    localparam int ACC_W       = 2*WORD_LENGTH+6;
    localparam int Q_SHIFT     = 15;

    localparam logic [WORD_LENGTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [WORD_LENGTH-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MAC   = 2'd2,
        STORE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LPF = 2'd0,
        BPF = 2'd1,
        HPF = 2'd2
    } filt_t;

    // Shift an accumulator back to Q1.15 and clamp to the word range.
    function automatic logic [WORD_LENGTH-1:0] sat_q15(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] sh;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        sh = acc >>> Q_SHIFT;
        hi = {{(ACC_W-WORD_LENGTH){1'b0}}, SAT_MAX};
        lo = {{(ACC_W-WORD_LENGTH){1'b1}}, SAT_MIN};
        if (sh > hi) begin
            return SAT_MAX;
        end else if (sh < lo) begin
            return SAT_MIN;
        end
        return sh[WORD_LENGTH-1:0];
    endfunction

endpackage

// File: rtl/fir_mac_scheduler_ring.sv
// sample_ring: per-channel 32-entry sample history with write pointer.
// Ports: clk_i, rst_ni (async low), we_i/wdata_i write, tap_i -> rdata_o.
module sample_ring
    import fir_sched_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [WORD_LENGTH-1:0] wdata_i,
    input  logic [TAP_W-1:0]       tap_i,
    output logic [WORD_LENGTH-1:0] rdata_o
);

    logic [WORD_LENGTH-1:0] mem_q [TAPS];
    logic [TAP_W-1:0]       wptr_q;

    // New sample lands one past the pointer, pointer then names the newest.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wptr_q + TAP_W'(1)] <= wdata_i;
            wptr_q                   <= wptr_q + TAP_W'(1);
        end
    end

    // Tap k is k samples older than the newest; 5-bit math wraps mod 32.
    assign rdata_o = mem_q[wptr_q - tap_i];

endmodule

// File: rtl/fir_mac_scheduler.sv
// Shared-MAC FIR engine: LPF/BPF/HPF for L and R, 32 taps, one multiplier.
// Ports: clk, reset (async low), shot_*/Channel_* in, coef_* ROM port,
// six filter outputs, done_*, busy, overrun_*. Option: MAC_ROUND_EN.
module fir_mac_scheduler
    import fir_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   shot_L,
    input  logic                   shot_R,
    input  logic [WORD_LENGTH-1:0] Channel_L,
    input  logic [WORD_LENGTH-1:0] Channel_R,
    output logic [1:0]             coef_sel,
    output logic [TAP_W-1:0]       coef_idx,
    input  logic [WORD_LENGTH-1:0] coef_data,
    output logic [WORD_LENGTH-1:0] LPF_L,
    output logic [WORD_LENGTH-1:0] BPF_L,
    output logic [WORD_LENGTH-1:0] HPF_L,
    output logic [WORD_LENGTH-1:0] LPF_R,
    output logic [WORD_LENGTH-1:0] BPF_R,
    output logic [WORD_LENGTH-1:0] HPF_R,
    output logic                   done_L,
    output logic                   done_R,
    output logic                   busy,
    output logic                   overrun_L,
    output logic                   overrun_R
);

    state_t                  state_q;
    filt_t                   filt_q;
    logic [TAP_W-1:0]        k_q;
    logic                    ch_q;
    logic                    rr_q;
    logic                    pend_l_q;
    logic                    pend_r_q;
    logic [WORD_LENGTH-1:0]  hold_l_q;
    logic [WORD_LENGTH-1:0]  hold_r_q;
    logic signed [ACC_W-1:0] acc_q;

    logic                      load_l;
    logic                      load_r;
    logic [WORD_LENGTH-1:0]    tap_l;
    logic [WORD_LENGTH-1:0]    tap_r;
    logic [WORD_LENGTH-1:0]    tap;
    logic signed [2*WORD_LENGTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   acc_rnd;
    logic [WORD_LENGTH-1:0]    res_d;

    assign load_l = (state_q == LOAD) && !ch_q;
    assign load_r = (state_q == LOAD) &&  ch_q;

    sample_ring u_ring_l (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (load_l),
        .wdata_i (hold_l_q),
        .tap_i   (k_q),
        .rdata_o (tap_l)
    );

    sample_ring u_ring_r (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (load_r),
        .wdata_i (hold_r_q),
        .tap_i   (k_q),
        .rdata_o (tap_r)
    );

    assign tap   = ch_q ? tap_r : tap_l;
    assign prod  = $signed(tap) * $signed(coef_data);
    assign acc_d = acc_q + ACC_W'(prod);

`ifdef MAC_ROUND_EN
    // Half an LSB of the result word: round-half-up before the shift.
    assign acc_rnd = acc_q + (ACC_W'(1) << (Q_SHIFT-1));
`else
    assign acc_rnd = acc_q;
`endif

    assign res_d = sat_q15(acc_rnd);

    assign coef_sel = (state_q == MAC) ? filt_q : 2'd0;
    assign coef_idx = (state_q == MAC) ? k_q : '0;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            filt_q    <= LPF;
            k_q       <= '0;
            ch_q      <= 1'b0;
            rr_q      <= 1'b0;
            pend_l_q  <= 1'b0;
            pend_r_q  <= 1'b0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            acc_q     <= '0;
            LPF_L     <= '0;
            BPF_L     <= '0;
            HPF_L     <= '0;
            LPF_R     <= '0;
            BPF_R     <= '0;
            HPF_R     <= '0;
            done_L    <= 1'b0;
            done_R    <= 1'b0;
            overrun_L <= 1'b0;
            overrun_R <= 1'b0;
        end else begin
            done_L <= 1'b0;
            done_R <= 1'b0;

            // A strobe during this channel's LOAD starts a fresh job,
            // it does not drop one, so it is not an overrun.
            overrun_L <= shot_L && pend_l_q && !load_l;
            overrun_R <= shot_R && pend_r_q && !load_r;
            pend_l_q  <= shot_L || (pend_l_q && !load_l);
            pend_r_q  <= shot_R || (pend_r_q && !load_r);
            if (shot_L) hold_l_q <= Channel_L;
            if (shot_R) hold_r_q <= Channel_R;

            unique case (state_q)
                IDLE: begin
                    if (pend_l_q || pend_r_q) begin
                        state_q <= LOAD;
                        // rr_q only moves on contention: it names the
                        // channel that wins the next tie.
                        if (pend_l_q && pend_r_q) begin
                            ch_q <= rr_q;
                            rr_q <= ~rr_q;
                        end else begin
                            ch_q <= pend_r_q;
                        end
                    end
                end
                LOAD: begin
                    acc_q   <= '0;
                    filt_q  <= LPF;
                    k_q     <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + TAP_W'(1);
                    if (k_q == TAP_W'(TAPS-1)) begin
                        state_q <= STORE;
                    end
                end
                STORE: begin
                    acc_q <= '0;
                    unique case ({ch_q, filt_q})
                        {1'b0, LPF}: LPF_L <= res_d;
                        {1'b0, BPF}: BPF_L <= res_d;
                        {1'b0, HPF}: HPF_L <= res_d;
                        {1'b1, LPF}: LPF_R <= res_d;
                        {1'b1, BPF}: BPF_R <= res_d;
                        {1'b1, HPF}: HPF_R <= res_d;
                        default: ;
                    endcase
                    if (filt_q == HPF) begin
                        done_L  <= !ch_q;
                        done_R  <= ch_q;
                        state_q <= IDLE;
                    end else begin
                        filt_q  <= (filt_q == LPF) ? BPF : HPF;
                        state_q <= MAC;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Testbench for fir_mac_scheduler: directed steps, direct-form FIR model,
// per-channel expected-result queues checked on every done pulse.
module tb_fir_mac_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        shot_L = 1'b0;
    logic        shot_R = 1'b0;
    logic [15:0] Channel_L = '0;
    logic [15:0] Channel_R = '0;
    logic [1:0]  coef_sel;
    logic [4:0]  coef_idx;
    logic [15:0] coef_data;
    logic [15:0] LPF_L, BPF_L, HPF_L, LPF_R, BPF_R, HPF_R;
    logic        done_L, done_R, busy, overrun_L, overrun_R;

    fir_mac_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .shot_L    (shot_L),
        .shot_R    (shot_R),
        .Channel_L (Channel_L),
        .Channel_R (Channel_R),
        .coef_sel  (coef_sel),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .LPF_L     (LPF_L),
        .BPF_L     (BPF_L),
        .HPF_L     (HPF_L),
        .LPF_R     (LPF_R),
        .BPF_R     (BPF_R),
        .HPF_R     (HPF_R),
        .done_L    (done_L),
        .done_R    (done_R),
        .busy      (busy),
        .overrun_L (overrun_L),
        .overrun_R (overrun_R)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l;
        logic [15:0] b;
        logic [15:0] h;
    } exp_t;

    logic signed [15:0] rom  [3][32];
    logic signed [15:0] save [3][32];
    logic signed [15:0] hist [2][32];
    exp_t expL [$];
    exp_t expR [$];

    int checks = 0;
    int errors = 0;
    int doneL_cnt = 0;
    int doneR_cnt = 0;

    assign coef_data = (coef_sel < 2'd3) ? rom[coef_sel][coef_idx] : 16'h0;

    localparam logic [15:0] IMP_LPF =
`ifdef MAC_ROUND_EN
        16'h002F;
`else
        16'h002E;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_out(input int ch, input int f);
        longint acc = 0;
        for (int k = 0; k < 32; k++) begin
            acc += longint'(hist[ch][k]) * longint'(rom[f][k]);
        end
`ifdef MAC_ROUND_EN
        acc += 64'sd16384;
`endif
        acc = acc >>> 15;
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return acc[15:0];
    endfunction

    task automatic push_model(input int ch, input logic [15:0] v);
        exp_t e;
        for (int k = 31; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = v;
        e.l = model_out(ch, 0);
        e.b = model_out(ch, 1);
        e.h = model_out(ch, 2);
        if (ch == 0) expL.push_back(e);
        else expR.push_back(e);
    endtask

    task automatic clear_model();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 32; k++) hist[c][k] = '0;
        expL.delete();
        expR.delete();
    endtask

    // Drives strobes so the following posedge is "edge 0"; returns at edge0+1.
    task automatic shot(input bit l, input bit r,
                        input logic [15:0] vl, input logic [15:0] vr,
                        input bit pl, input bit pr);
        @(negedge clk);
        shot_L = l;
        shot_R = r;
        Channel_L = vl;
        Channel_R = vr;
        if (pl) push_model(0, vl);
        if (pr) push_model(1, vr);
        @(posedge clk);
        #1;
        shot_L = 1'b0;
        shot_R = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done_L) begin
            doneL_cnt++;
            if (expL.size() == 0) begin
                chk("L_unexpected_done", 32'd0, 32'd1);
            end else begin
                e = expL.pop_front();
                chk("LPF_L", LPF_L, e.l);
                chk("BPF_L", BPF_L, e.b);
                chk("HPF_L", HPF_L, e.h);
            end
        end
        if (done_R) begin
            doneR_cnt++;
            if (expR.size() == 0) begin
                chk("R_unexpected_done", 32'd0, 32'd1);
            end else begin
                e = expR.pop_front();
                chk("LPF_R", LPF_R, e.l);
                chk("BPF_R", BPF_R, e.b);
                chk("HPF_R", HPF_R, e.h);
            end
        end
    end

    initial begin
        int d0;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 32; k++)
                rom[f][k] = 16'($urandom_range(0, 65535));
        rom[0][0] = 16'h002F;
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_LPF_L", LPF_L, 0);
        chk("rst_HPF_R", HPF_R, 0);
        chk("rst_busy", busy, 0);
        chk("rst_coef_sel", coef_sel, 0);
        chk("rst_done", {done_L, done_R, overrun_L, overrun_R}, 0);
        @(negedge clk);
        reset = 1'b1;
        edges(2);

        // Impulse with exact timing
        shot(1, 0, 16'h7FFF, 16'h0, 1, 0);
        edges(1);
        chk("imp_busy_e1", busy, 1);
        edges(33);
        chk("imp_LPF_e34", LPF_L, 0);
        edges(1);
        chk("imp_LPF_e35", LPF_L, IMP_LPF);
        edges(5);
        chk("imp_sel_e40", coef_sel, 1);
        chk("imp_idx_e40", coef_idx, 5);
        edges(60);
        chk("imp_done_e100", done_L, 0);
        edges(1);
        chk("imp_done_e101", done_L, 1);
        chk("imp_busy_e101", busy, 0);
        edges(1);
        chk("imp_done_e102", done_L, 0);
        chk("imp_R_untouched", LPF_R, 0);
        chk("imp_idx_idle", coef_idx, 0);
        edges(8);

        // Impulse walk through all taps, then out of the window
        for (int n = 1; n <= 32; n++) begin
            shot(1, 0, 16'h0000, 16'h0, 1, 0);
            edges(108);
        end
        chk("walk_end_LPF", LPF_L, 0);
        chk("walk_end_BPF", BPF_L, 0);
        chk("walk_end_HPF", HPF_L, 0);

        // Simultaneous strobes: L first after reset, then R wins the tie
        shot(1, 1, 16'h1234, 16'hC0DE, 1, 1);
        edges(101);
        chk("sim1_doneL", {done_L, done_R}, 2'b10);
        edges(101);
        chk("sim1_doneR", {done_L, done_R}, 2'b01);
        edges(10);
        shot(1, 1, 16'h4321, 16'h0F0F, 1, 1);
        edges(101);
        chk("sim2_doneR", {done_L, done_R}, 2'b01);
        edges(101);
        chk("sim2_doneL", {done_L, done_R}, 2'b10);
        edges(10);

        // Overrun: newest sample wins, exactly two jobs
        d0 = doneL_cnt;
        shot(1, 0, 16'h5555, 16'h0, 1, 0);
        edges(9);
        shot(1, 0, 16'h1111, 16'h0, 0, 0);
        chk("ovr_e10", overrun_L, 0);
        edges(9);
        shot(1, 0, 16'h2222, 16'h0, 1, 0);
        chk("ovr_e20", overrun_L, 1);
        edges(1);
        chk("ovr_e21", overrun_L, 0);
        edges(230);
        chk("ovr_done_count", doneL_cnt - d0, 2);

        // Saturation both ways
        save = rom;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 32; k++) rom[f][k] = 16'h7FFF;
        for (int n = 0; n < 32; n++) begin
            shot(1, 0, 16'h7FFF, 16'h0, 1, 0);
            edges(108);
        end
        chk("sat_pos", LPF_L, 16'h7FFF);
        for (int n = 0; n < 32; n++) begin
            shot(1, 0, 16'h8000, 16'h0, 1, 0);
            edges(108);
        end
        chk("sat_neg", LPF_L, 16'h8000);
        rom = save;

        // Reset in the middle of a job
        shot(1, 0, 16'h7FFF, 16'h0, 1, 0);
        edges(50);
        reset = 1'b0;
        #1;
        chk("mid_rst_LPF_L", LPF_L, 0);
        chk("mid_rst_BPF_R", BPF_R, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done_L, 0);
        clear_model();
        d0 = doneL_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        edges(120);
        chk("mid_rst_no_done", doneL_cnt - d0, 0);
        shot(1, 0, 16'h7FFF, 16'h0, 1, 0);
        edges(35);
        chk("post_rst_LPF", LPF_L, IMP_LPF);
        edges(75);

        chk("expL_drained", expL.size(), 0);
        chk("expR_drained", expR.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
